// File: rtl/wb_resize_pkg.sv
// -----------------------------------------------------------------------------
// wb_resize_pkg
// Shared definitions for the sequential Wishbone data-width downsizer:
//   state_t      - FSM state encoding (IDLE, ISSUE, DONE, ERR, RTY)
//   CTI_CLASSIC  - cycle type driven on the narrow bus (classic cycle)
//   BTE_LINEAR   - burst type driven on the narrow bus (linear, unused)
//   lane_count() - number of narrow lanes packed into one wide word
//   log2_ceil()  - ceiling log2, used for lane index and byte-offset widths
// -----------------------------------------------------------------------------
package wb_resize_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_DONE  = 3'd2,
      ST_ERR   = 3'd3,
      ST_RTY   = 3'd4
   } state_t;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [1:0] BTE_LINEAR  = 2'b00;

   function automatic int lane_count(input int mdw, input int sdw);
      return mdw / sdw;
   endfunction

   function automatic int log2_ceil(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/wb_lane_select.sv
// -----------------------------------------------------------------------------
// wb_lane_select
// Combinational priority encoder over the lane-active mask. Returns the lowest
// active lane whose index is >= start.
//   mask      in  [lanes-1:0] : one bit per narrow lane, 1 = lane has sel bits
//   start     in  [lw:0]      : first index to consider (may equal lanes)
//   lane      out [lw-1:0]    : lowest active lane >= start (0 if none)
//   none_left out             : no active lane at or above start
// start is one bit wider than a lane index so "current lane + 1" can point
// past the last lane without wrapping back to lane 0.
// -----------------------------------------------------------------------------
module wb_lane_select
   import wb_resize_pkg::*;
#(
   parameter int lanes = 4,
   parameter int lw    = 2
) (
   input  logic [lanes-1:0] mask,
   input  logic [lw:0]      start,
   output logic [lw-1:0]    lane,
   output logic             none_left
);

   always_comb begin
      lane      = '0;
      none_left = 1'b1;
      // Walk downwards so the lowest qualifying index is the one that sticks.
      for (int j = lanes - 1; j >= 0; j--) begin
         if (mask[j] && (int'(start) <= j)) begin
            lane      = lw'(j);
            none_left = 1'b0;
         end
      end
   end

endmodule

// File: rtl/wb_data_resize_seq.sv
// -----------------------------------------------------------------------------
// wb_data_resize_seq
// Sequential Wishbone downsizer: one wide master access becomes one narrow
// slave access per active byte-lane group, big-endian lane order (lane 0 is
// the most significant slice). Read data is gathered into a register and a
// single registered ack/err/rty is returned to the master.
//
// Ports
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   wbm_adr_i/dat_i/sel_i/we_i : wide master request
//   wbm_cyc_i/stb_i            : master cycle / strobe
//   wbm_cti_i/bte_i            : master burst info (bursts run as single accesses)
//   wbm_dat_o                  : gathered read data (inactive lanes read 0)
//   wbm_ack_o/err_o/rty_o      : one-cycle master response pulses
//   wbs_adr_o/dat_o/we_o       : narrow slave request
//   wbs_cyc_o/stb_o            : slave cycle / strobe
//   wbs_cti_o/bte_o            : always classic / linear
//   wbs_dat_i                  : narrow read data
//   wbs_ack_i/err_i/rty_i      : slave response
//
// Handshake: a master access is taken when cyc&stb are seen in IDLE; the
// slave transfer for a lane completes in any cycle where wbs_stb_o is high and
// the slave raises ack, err or rty (err beats rty beats ack); the master
// transfer completes with exactly one cycle of ack, err or rty. Dropping
// wbm_cyc_i while lanes are in flight abandons the access silently.
// The FSM state is held in the signal `state` (type state_t).
// -----------------------------------------------------------------------------
module wb_data_resize_seq
   import wb_resize_pkg::*;
#(
   parameter int aw  = 32,
   parameter int mdw = 32,
   parameter int sdw = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [aw-1:0]     wbm_adr_i,
   input  logic [mdw-1:0]    wbm_dat_i,
   input  logic [mdw/8-1:0]  wbm_sel_i,
   input  logic              wbm_we_i,
   input  logic              wbm_cyc_i,
   input  logic              wbm_stb_i,
   input  logic [2:0]        wbm_cti_i,
   input  logic [1:0]        wbm_bte_i,
   output logic [mdw-1:0]    wbm_dat_o,
   output logic              wbm_ack_o,
   output logic              wbm_err_o,
   output logic              wbm_rty_o,
   output logic [aw-1:0]     wbs_adr_o,
   output logic [sdw-1:0]    wbs_dat_o,
   output logic              wbs_we_o,
   output logic              wbs_cyc_o,
   output logic              wbs_stb_o,
   output logic [2:0]        wbs_cti_o,
   output logic [1:0]        wbs_bte_o,
   input  logic [sdw-1:0]    wbs_dat_i,
   input  logic              wbs_ack_i,
   input  logic              wbs_err_i,
   input  logic              wbs_rty_i
);

   localparam int R  = lane_count(mdw, sdw);
   localparam int LW = log2_ceil(R);
   localparam int SB = sdw / 8;            // sel bits / address bytes per lane
   localparam int AB = log2_ceil(mdw / 8); // address bits below one wide word

   state_t          state, state_n;
   logic [LW-1:0]   lane, lane_n;
   logic [aw-1:0]   base_q, base_n;
   logic [mdw-1:0]  dat_q, dat_n;
   logic [R-1:0]    mask_q, mask_n;
   logic            we_q, we_n;
   logic [mdw-1:0]  rd_q, rd_n;

   logic [aw-1:0]   s_adr_n;
   logic [sdw-1:0]  s_dat_n;
   logic            s_we_n, s_cyc_n, s_stb_n;
   logic            m_ack_n, m_err_n, m_rty_n;

   logic            issue;
   logic [aw-1:0]   iss_base;
   logic [mdw-1:0]  iss_dat;
   logic            iss_we;
   logic [LW-1:0]   iss_lane;

   // Burst hints and sub-word address bits have no meaning on the narrow side.
   logic unused_bits;
   assign unused_bits = ^{wbm_cti_i, wbm_bte_i, wbm_adr_i[AB-1:0]};

   // Wide-word-aligned base address of the incoming request.
   logic [aw-1:0] base_in;
   assign base_in = {wbm_adr_i[aw-1:AB], {AB{1'b0}}};

   // A lane is active when any sel bit of its group is set.
   logic [R-1:0] mask_in;
   always_comb begin
      mask_in = '0;
      for (int j = 0; j < R; j++) begin
         mask_in[j] = |wbm_sel_i[mdw/8-1-j*SB -: SB];
      end
   end

   logic [LW-1:0] first_lane, next_lane;
   logic          first_none, next_none;
   logic [LW:0]   next_start;
   assign next_start = {1'b0, lane} + {{LW{1'b0}}, 1'b1};

   wb_lane_select #(.lanes(R), .lw(LW)) u_first_sel (
      .mask      (mask_in),
      .start     ('0),
      .lane      (first_lane),
      .none_left (first_none)
   );

   wb_lane_select #(.lanes(R), .lw(LW)) u_next_sel (
      .mask      (mask_q),
      .start     (next_start),
      .lane      (next_lane),
      .none_left (next_none)
   );

   function automatic logic [aw-1:0] lane_adr(input logic [aw-1:0] base,
                                              input logic [LW-1:0] l);
      return base + aw'(l) * aw'(SB);
   endfunction

   function automatic logic [sdw-1:0] lane_dat(input logic [mdw-1:0] d,
                                               input logic [LW-1:0]  l);
      logic [sdw-1:0] v;
      v = '0;
      for (int j = 0; j < R; j++) begin
         if (l == LW'(j)) v = d[mdw-1-j*sdw -: sdw];
      end
      return v;
   endfunction

   function automatic logic [mdw-1:0] lane_put(input logic [mdw-1:0] d,
                                               input logic [LW-1:0]  l,
                                               input logic [sdw-1:0] v);
      logic [mdw-1:0] r;
      r = d;
      for (int j = 0; j < R; j++) begin
         if (l == LW'(j)) r[mdw-1-j*sdw -: sdw] = v;
      end
      return r;
   endfunction

   // Next-state and next-output logic. Every slave/master output is a flop,
   // so this block computes what they must show in the following cycle.
   always_comb begin
      state_n  = state;
      lane_n   = lane;
      base_n   = base_q;
      dat_n    = dat_q;
      mask_n   = mask_q;
      we_n     = we_q;
      rd_n     = rd_q;
      m_ack_n  = 1'b0;
      m_err_n  = 1'b0;
      m_rty_n  = 1'b0;
      issue    = 1'b0;
      iss_base = base_q;
      iss_dat  = dat_q;
      iss_we   = we_q;
      iss_lane = lane;

      case (state)
         ST_IDLE: begin
            if (wbm_cyc_i && wbm_stb_i) begin
               base_n = base_in;
               dat_n  = wbm_dat_i;
               mask_n = mask_in;
               we_n   = wbm_we_i;
               rd_n   = '0;
               if (first_none) begin
                  state_n = ST_DONE;
                  m_ack_n = 1'b1;
               end else begin
                  // First lane goes out straight from the inputs since the
                  // latches only update at this same edge.
                  state_n  = ST_ISSUE;
                  lane_n   = first_lane;
                  issue    = 1'b1;
                  iss_base = base_in;
                  iss_dat  = wbm_dat_i;
                  iss_we   = wbm_we_i;
                  iss_lane = first_lane;
               end
            end
         end

         ST_ISSUE: begin
            if (!wbm_cyc_i) begin
               state_n = ST_IDLE;
            end else if (wbs_err_i) begin
               state_n = ST_ERR;
               m_err_n = 1'b1;
            end else if (wbs_rty_i) begin
               state_n = ST_RTY;
               m_rty_n = 1'b1;
            end else if (wbs_ack_i) begin
               rd_n = lane_put(rd_q, lane, wbs_dat_i);
               if (next_none) begin
                  state_n = ST_DONE;
                  m_ack_n = 1'b1;
               end else begin
                  lane_n   = next_lane;
                  issue    = 1'b1;
                  iss_lane = next_lane;
               end
            end else begin
               issue = 1'b1;   // slave wait state: hold the current lane
            end
         end

         ST_DONE, ST_ERR, ST_RTY: state_n = ST_IDLE;

         default: state_n = ST_IDLE;
      endcase

      s_cyc_n = issue;
      s_stb_n = issue;
      s_we_n  = issue & iss_we;
      s_adr_n = issue ? lane_adr(iss_base, iss_lane) : '0;
      s_dat_n = (issue && iss_we) ? lane_dat(iss_dat, iss_lane) : '0;
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         lane      <= '0;
         base_q    <= '0;
         dat_q     <= '0;
         mask_q    <= '0;
         we_q      <= 1'b0;
         rd_q      <= '0;
         wbm_ack_o <= 1'b0;
         wbm_err_o <= 1'b0;
         wbm_rty_o <= 1'b0;
         wbs_adr_o <= '0;
         wbs_dat_o <= '0;
         wbs_we_o  <= 1'b0;
         wbs_cyc_o <= 1'b0;
         wbs_stb_o <= 1'b0;
      end else begin
         state     <= state_n;
         lane      <= lane_n;
         base_q    <= base_n;
         dat_q     <= dat_n;
         mask_q    <= mask_n;
         we_q      <= we_n;
         rd_q      <= rd_n;
         wbm_ack_o <= m_ack_n;
         wbm_err_o <= m_err_n;
         wbm_rty_o <= m_rty_n;
         wbs_adr_o <= s_adr_n;
         wbs_dat_o <= s_dat_n;
         wbs_we_o  <= s_we_n;
         wbs_cyc_o <= s_cyc_n;
         wbs_stb_o <= s_stb_n;
      end
   end

   assign wbm_dat_o = rd_q;
   assign wbs_cti_o = CTI_CLASSIC;
   assign wbs_bte_o = BTE_LINEAR;

endmodule

// File: tb/tb_wb_data_resize_seq.sv
// -----------------------------------------------------------------------------
// tb_wb_data_resize_seq
// Directed bench for wb_data_resize_seq (aw=32, mdw=32, sdw=8). The initial
// block plays both the master and a configurable narrow slave (wait states,
// err or rty on a chosen strobe). Expected slave accesses, tagged with the
// cycle they should complete in, are queued when a master access is started
// and popped as the slave answers them.
// -----------------------------------------------------------------------------
module tb_wb_data_resize_seq;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic [31:0] wbm_adr_i;
   logic [31:0] wbm_dat_i;
   logic [3:0]  wbm_sel_i;
   logic        wbm_we_i, wbm_cyc_i, wbm_stb_i;
   logic [2:0]  wbm_cti_i;
   logic [1:0]  wbm_bte_i;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
   logic [31:0] wbs_adr_o;
   logic [7:0]  wbs_dat_o;
   logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
   logic [2:0]  wbs_cti_o;
   logic [1:0]  wbs_bte_o;
   logic [7:0]  wbs_dat_i;
   logic        wbs_ack_i, wbs_err_i, wbs_rty_i;

   wb_data_resize_seq #(.aw(32), .mdw(32), .sdw(8)) dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .wbm_adr_i (wbm_adr_i),
      .wbm_dat_i (wbm_dat_i),
      .wbm_sel_i (wbm_sel_i),
      .wbm_we_i  (wbm_we_i),
      .wbm_cyc_i (wbm_cyc_i),
      .wbm_stb_i (wbm_stb_i),
      .wbm_cti_i (wbm_cti_i),
      .wbm_bte_i (wbm_bte_i),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_o (wbm_ack_o),
      .wbm_err_o (wbm_err_o),
      .wbm_rty_o (wbm_rty_o),
      .wbs_adr_o (wbs_adr_o),
      .wbs_dat_o (wbs_dat_o),
      .wbs_we_o  (wbs_we_o),
      .wbs_cyc_o (wbs_cyc_o),
      .wbs_stb_o (wbs_stb_o),
      .wbs_cti_o (wbs_cti_o),
      .wbs_bte_o (wbs_bte_o),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_i (wbs_ack_i),
      .wbs_err_i (wbs_err_i),
      .wbs_rty_i (wbs_rty_i)
   );

   // ---------------- clock ----------------
   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   // ---------------- scoreboard state ----------------
   // entry = {cycle[7:0], we, adr[31:0], dat[7:0]}
   logic [48:0] exp_q[$];
   logic [7:0]  slave_rd_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int s_waits  = 0;
   int s_err_at = 0;
   int s_rty_at = 0;
   int n_stb    = 0;
   int stb_cycles = 0;

   int          resp_c;
   logic [2:0]  resp;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic push_exp(input int cyc, input logic we, input logic [31:0] adr,
                           input logic [7:0] dat);
      exp_q.push_back({8'(cyc), we, adr, dat});
   endtask

   task automatic start(input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we);
      wbm_adr_i = adr;
      wbm_dat_i = dat;
      wbm_sel_i = sel;
      wbm_we_i  = we;
      wbm_cti_i = 3'($urandom_range(0, 7));
      wbm_bte_i = 2'($urandom_range(0, 3));
      wbm_cyc_i = 1'b1;
      wbm_stb_i = 1'b1;
      n_stb      = 0;
      stb_cycles = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mdat"}, wbm_dat_o, 32'h0);
      chk({tag, "_mresp"}, {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
      chk({tag, "_sadr"}, wbs_adr_o, 32'h0);
      chk({tag, "_sdat"}, wbs_dat_o, 8'h0);
      chk({tag, "_sctl"}, {wbs_we_o, wbs_cyc_o, wbs_stb_o}, 3'b000);
      chk({tag, "_ctibte"}, {wbs_cti_o, wbs_bte_o}, 5'b0);
   endtask

   // Runs cycles after start(): cycle c = 1 is the first cycle after the
   // request was presented. Plays the slave and stops at the master response,
   // at drop_c (master abandons) or at rst_c (reset pulse).
   task automatic run(input int max_c, input int drop_c, input int rst_c, input bit hold,
                      output int rc, output logic [2:0] rsp);
      int          wait_cnt;
      logic [48:0] e;
      wait_cnt = 0;
      rc  = 0;
      rsp = 3'b000;
      for (int c = 1; c <= max_c; c++) begin
         tick();
         wbs_ack_i = 1'b0;
         wbs_err_i = 1'b0;
         wbs_rty_i = 1'b0;
         wbs_dat_i = 8'h0;
         if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
            rc  = c;
            rsp = {wbm_ack_o, wbm_err_o, wbm_rty_o};
            chk("resp_slave_idle", {wbs_cyc_o, wbs_stb_o}, 2'b00);
            if (!hold) begin
               wbm_cyc_i = 1'b0;
               wbm_stb_i = 1'b0;
            end
            return;
         end
         if (c == drop_c) begin
            wbm_cyc_i = 1'b0;
            wbm_stb_i = 1'b0;
            tick();
            chk("abort_slave_idle", {wbs_cyc_o, wbs_stb_o}, 2'b00);
            for (int k = 0; k < 4; k++) begin
               chk("abort_no_resp", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
               chk("abort_no_stb", wbs_stb_o, 1'b0);
               tick();
            end
            return;
         end
         if (c == rst_c) begin
            wb_rst_i  = 1'b1;
            wbm_cyc_i = 1'b0;
            wbm_stb_i = 1'b0;
            tick();
            chk_all_zero("midrst");
            wb_rst_i = 1'b0;
            return;
         end
         if (wbs_stb_o) begin
            stb_cycles++;
            if (wait_cnt < s_waits) begin
               wait_cnt++;
            end else begin
               wait_cnt = 0;
               n_stb++;
               chk("sb_pending", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("stb_cycle", 8'(c), e[48:41]);
                  chk("stb_we", wbs_we_o, e[40]);
                  chk("stb_adr", wbs_adr_o, e[39:8]);
                  chk("stb_dat", wbs_dat_o, e[7:0]);
                  chk("stb_cyc", wbs_cyc_o, 1'b1);
                  chk("stb_ctibte", {wbs_cti_o, wbs_bte_o}, 5'b0);
               end
               if (n_stb == s_err_at) begin
                  wbs_err_i = 1'b1;
                  wbs_ack_i = 1'b1;
                  wbs_dat_i = 8'($urandom_range(0, 255));
               end else if (n_stb == s_rty_at) begin
                  wbs_rty_i = 1'b1;
                  wbs_ack_i = 1'b1;
                  wbs_dat_i = 8'($urandom_range(0, 255));
               end else begin
                  wbs_ack_i = 1'b1;
                  if (!wbs_we_o && slave_rd_q.size() != 0) wbs_dat_i = slave_rd_q.pop_front();
                  else wbs_dat_i = 8'($urandom_range(0, 255));
               end
            end
         end
      end
   endtask

   task automatic after_resp();
      tick();
      chk("resp_one_cycle", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b000);
      chk("idle_no_stb", wbs_stb_o, 1'b0);
   endtask

   initial begin
      wb_rst_i  = 1'b1;
      wbm_adr_i = '0;
      wbm_dat_i = '0;
      wbm_sel_i = '0;
      wbm_we_i  = 1'b0;
      wbm_cyc_i = 1'b0;
      wbm_stb_i = 1'b0;
      wbm_cti_i = '0;
      wbm_bte_i = '0;
      wbs_dat_i = '0;
      wbs_ack_i = 1'b0;
      wbs_err_i = 1'b0;
      wbs_rty_i = 1'b0;

      // Reset state
      tick(); tick(); tick();
      chk_all_zero("reset");
      wb_rst_i = 1'b0;
      tick();

      // Four-lane write, zero-wait slave
      start(32'h9000_0004, 32'hA1B2_C3D4, 4'b1111, 1'b1);
      push_exp(1, 1'b1, 32'h9000_0004, 8'hA1);
      push_exp(2, 1'b1, 32'h9000_0005, 8'hB2);
      push_exp(3, 1'b1, 32'h9000_0006, 8'hC3);
      push_exp(4, 1'b1, 32'h9000_0007, 8'hD4);
      run(20, 0, 0, 1'b0, resp_c, resp);
      chk("wr4_resp_cycle", resp_c, 5);
      chk("wr4_resp_kind", resp, 3'b100);
      chk("wr4_stb_cycles", stb_cycles, 4);
      after_resp();

      // Sparse read, sel 0101
      start(32'h9000_0000, 32'h0, 4'b0101, 1'b0);
      push_exp(1, 1'b0, 32'h9000_0001, 8'h00);
      push_exp(2, 1'b0, 32'h9000_0003, 8'h00);
      slave_rd_q.push_back(8'h11);
      slave_rd_q.push_back(8'h22);
      run(20, 0, 0, 1'b0, resp_c, resp);
      chk("rd2_resp_cycle", resp_c, 3);
      chk("rd2_resp_kind", resp, 3'b100);
      chk("rd2_data", wbm_dat_o, 32'h0011_0022);
      after_resp();
      chk("rd2_data_persist", wbm_dat_o, 32'h0011_0022);

      // No lanes enabled: immediate ack, no strobe, read register cleared
      start(32'h9000_0008, 32'h0, 4'b0000, 1'b0);
      run(20, 0, 0, 1'b0, resp_c, resp);
      chk("sel0_resp_cycle", resp_c, 1);
      chk("sel0_resp_kind", resp, 3'b100);
      chk("sel0_stb_cycles", stb_cycles, 0);
      chk("sel0_data_cleared", wbm_dat_o, 32'h0);
      after_resp();

      // err (with ack) on the second lane: err wins
      s_err_at = 2;
      start(32'h9000_0010, 32'h0102_0304, 4'b1111, 1'b1);
      push_exp(1, 1'b1, 32'h9000_0010, 8'h01);
      push_exp(2, 1'b1, 32'h9000_0011, 8'h02);
      run(20, 0, 0, 1'b0, resp_c, resp);
      chk("err_resp_cycle", resp_c, 3);
      chk("err_resp_kind", resp, 3'b010);
      chk("err_strobes", n_stb, 2);
      after_resp();
      s_err_at = 0;

      // rty (with ack) on the first lane: rty wins, nothing gathered
      s_rty_at = 1;
      start(32'h9000_0030, 32'h0, 4'b0011, 1'b0);
      push_exp(1, 1'b0, 32'h9000_0032, 8'h00);
      run(20, 0, 0, 1'b0, resp_c, resp);
      chk("rty_resp_cycle", resp_c, 2);
      chk("rty_resp_kind", resp, 3'b001);
      chk("rty_data", wbm_dat_o, 32'h0);
      after_resp();
      s_rty_at = 0;

      // Read with two slave wait states per lane
      s_waits = 2;
      start(32'h9000_0020, 32'h0, 4'b1100, 1'b0);
      push_exp(3, 1'b0, 32'h9000_0020, 8'h00);
      push_exp(6, 1'b0, 32'h9000_0021, 8'h00);
      slave_rd_q.push_back(8'hAB);
      slave_rd_q.push_back(8'hCD);
      run(30, 0, 0, 1'b0, resp_c, resp);
      chk("wait_resp_cycle", resp_c, 7);
      chk("wait_resp_kind", resp, 3'b100);
      chk("wait_data", wbm_dat_o, 32'hABCD_0000);
      after_resp();
      s_waits = 0;

      // Back-to-back: master keeps cyc/stb up with a new request at the response
      start(32'h9000_0040, 32'hEE00_0000, 4'b1000, 1'b1);
      push_exp(1, 1'b1, 32'h9000_0040, 8'hEE);
      run(20, 0, 0, 1'b1, resp_c, resp);
      chk("b2b_first_resp", resp_c, 2);
      start(32'h9000_0044, 32'h0000_00FF, 4'b0001, 1'b1);
      push_exp(2, 1'b1, 32'h9000_0047, 8'hFF);
      run(20, 0, 0, 1'b0, resp_c, resp);
      chk("b2b_second_resp", resp_c, 3);
      chk("b2b_second_kind", resp, 3'b100);
      after_resp();

      // Reset during lane 2 with a 3-wait-state slave
      s_waits = 3;
      start(32'h9000_0050, 32'h1122_3344, 4'b1111, 1'b1);
      push_exp(4, 1'b1, 32'h9000_0050, 8'h11);
      push_exp(8, 1'b1, 32'h9000_0051, 8'h22);
      run(30, 0, 10, 1'b0, resp_c, resp);
      chk("midrst_no_resp", resp_c, 0);
      chk("midrst_sb_drained", exp_q.size(), 0);
      s_waits = 0;
      tick();
      chk("midrst_quiet", {wbs_cyc_o, wbs_stb_o, wbm_ack_o}, 3'b000);
      start(32'h9000_0000, 32'h5A00_0000, 4'b1000, 1'b1);
      push_exp(1, 1'b1, 32'h9000_0000, 8'h5A);
      run(20, 0, 0, 1'b0, resp_c, resp);
      chk("postrst_resp_cycle", resp_c, 2);
      chk("postrst_resp_kind", resp, 3'b100);
      after_resp();

      // Master drops cyc during lane 1
      s_waits = 2;
      start(32'h9000_0060, 32'h0, 4'b1111, 1'b0);
      push_exp(3, 1'b0, 32'h9000_0060, 8'h00);
      slave_rd_q.push_back(8'h77);
      run(30, 5, 0, 1'b0, resp_c, resp);
      chk("drop_no_resp", resp_c, 0);
      s_waits = 0;

      chk("final_sb_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
